wb_ram_slave: RTL and testbench
===============================

Name: wb_ram_slave

Overview:
Wishbone B4 pipelined responder backed by a single-port word RAM. It sits on one slave port of the bus mux and answers the CPU instruction/data master. It has configurable fixed response latency, byte-lane writes, cycle-abort flushing and optional periodic stall injection, so masters can be exercised under backpressure.

Parameters:
BYTES, 32, data/address width in bits (bus naming kept); BYTES/8 byte lanes
DEPTH, 1024, RAM depth in words; power of two, >= 2
LATENCY, 1, cycles from request acceptance to ack; legal 1..4
STALL_PERIOD, 0, 0 = never stall; N >= 2 = stall asserted one cycle in every N

Ports:
i_clk  in  1  clock; everything rises on posedge
i_rst  in  1  synchronous reset, active-high
i_wb_cyc  in  1  bus cycle active
i_wb_stb  in  1  request strobe (already gated by mux select)
i_wb_we  in  1  1 = write, 0 = read
i_wb_addr  in  BYTES  byte address
i_wb_data  in  BYTES  write data
i_wb_sel  in  BYTES/8  byte enables, bit k = bits [8k+7:8k]
o_wb_stall  out  1  request not accepted this cycle
o_wb_ack  out  1  one-cycle response strobe per accepted request
o_wb_data  out  BYTES  read data, valid only while o_wb_ack=1 for a read

Behaviour:
- Reset: one clock, synchronous active-high (i_rst, sampled at posedge i_clk).
- Reset values: o_wb_ack=0, o_wb_data=0, pipeline valid bits=0, stall counter=0. o_wb_stall=1 while i_rst=1.
- RAM contents are not cleared by reset.
- Word index = i_wb_addr[2 +: log2(DEPTH)]. The low 2 bits and the upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Accept: a request is accepted in cycle t iff i_wb_cyc & i_wb_stb & !o_wb_stall. At most one request per cycle.
- Write: committed at the accept edge, per byte lane where i_wb_sel[k]=1. sel=0 is a legal write that changes nothing and is still acked.
- Read:
  - RAM is read at the accept edge.
  - Data is the word state before any write accepted in the same cycle; only one request is accepted per cycle, so this only matters across cycles.
  - A read accepted in cycle t+1 after a write in cycle t returns the new data.
  - i_wb_sel is ignored for reads; the full word is returned.
- Response pipeline:
  - LATENCY stages of {valid, data}.
  - Request accepted at edge t gives o_wb_ack=1 during cycle t+LATENCY, exactly one cycle per request, in order.
  - For LATENCY=1 the ack comes the cycle after acceptance.
  - o_wb_data = 0 when o_wb_ack=0 and for write acks.
- Throughput: one accept per cycle with no stall injection, so up to LATENCY acks are outstanding.
- Stall injection:
  - STALL_PERIOD=0: o_wb_stall=0 whenever i_rst=0.
  - STALL_PERIOD=N: a free-running counter runs 0..N-1 and wraps, and increments regardless of bus activity. o_wb_stall=1 when counter==N-1.
  - A stalled request is not accepted; the master holds it, per B4 rules.
- Abort: i_wb_cyc=0 in any cycle clears all pipeline valid bits at that edge.
  - No ack is issued for requests outstanding at that point.
  - Writes already accepted stay committed.
  - o_wb_ack is forced to 0 combinationally while i_wb_cyc=0.
- stb without cyc: ignored.
- cyc with stb=0: no accept; the pipeline drains normally.
- Reset mid-transaction:
  - All outstanding acks are dropped.
  - A request presented during the reset cycle is not accepted (stall=1).
  - Writes already committed remain.

Test Plan:
- LATENCY=1: write 0xDEADBEEF to addr 0x10 (sel=0xF), then read 0x10 the next cycle. Required: ack at t+1 and t+2; read data 0xDEADBEEF; stall stays 0.
- Byte lanes: write 0x11223344 to 0x20, then write 0xAABBCCDD sel=0x5 to 0x20, then read 0x20. Required: data 0x11BB33DD.
- LATENCY=3 back-to-back: reads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3) on consecutive cycles. Required: acks on three consecutive cycles starting 3 cycles after the first accept; data 1, 2, 3 in order.
- STALL_PERIOD=4, master holds stb continuously for 8 reads. Required:
  - o_wb_stall high every 4th cycle after reset release.
  - Exactly 8 acks, in order.
  - No request lost or duplicated.
- Abort with LATENCY=3: issue write 0x55 to 0x40, drop cyc one cycle after accept, then read 0x40 in a new cycle. Required:
  - No ack for the aborted write.
  - The new read returns 0x55.
- Wrap and reset, DEPTH=1024: write 0x77 to addr 0x1000, read addr 0x0 → 0x77. Assert i_rst with 2 reads outstanding. Required: no ack is issued afterwards; o_wb_ack=0 and o_wb_data=0 the cycle after reset.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined slave backed by a single-port word RAM, with a fixed
// response latency, byte-lane writes, abort flushing and optional stall injection.
module wb_ram_slave #(
  parameter int BYTES        = 32,
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 1,
  parameter int STALL_PERIOD = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [BYTES-1:0]   i_wb_addr,
  input  logic [BYTES-1:0]   i_wb_data,
  input  logic [BYTES/8-1:0] i_wb_sel,
  output logic               o_wb_stall,
  output logic               o_wb_ack,
  output logic [BYTES-1:0]   o_wb_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = BYTES / 8;
  localparam int CW    = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

  logic [AW-1:0]      word_idx;
  logic               accept;
  logic               stall_tick;
  logic [LANES-1:0]   lane_we;
  logic               unused_addr_bits;

  logic [BYTES-1:0]   mem [DEPTH];
  logic [BYTES-1:0]   data_pipe_reg [LATENCY];
  logic [LATENCY-1:0] valid_reg;
  logic [LATENCY-1:0] rd_reg;

  assign word_idx   = i_wb_addr[2 +: AW];
  assign o_wb_stall = i_rst | stall_tick;
  assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;

  // Byte offset and bits above the RAM window are don't-care (address wraps).
  if (AW + 2 < BYTES) begin : g_addr_hi
    assign unused_addr_bits = ^{i_wb_addr[BYTES-1:AW+2], i_wb_addr[1:0]};
  end else begin : g_addr_lo
    assign unused_addr_bits = ^i_wb_addr[1:0];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_we[gi] = accept & i_wb_we & i_wb_sel[gi];
  end

  // RAM plus data pipeline: no reset so the array and its read register map
  // onto block RAM; validity is tracked separately below.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (lane_we[k]) begin
        mem[word_idx][8*k +: 8] <= i_wb_data[8*k +: 8];
      end
    end
    if (accept && !i_wb_we) begin
      data_pipe_reg[0] <= mem[word_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      data_pipe_reg[i] <= data_pipe_reg[i-1];
    end
  end

  // Dropping cyc flushes every outstanding response.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_wb_cyc) begin
      valid_reg <= '0;
      rd_reg    <= '0;
    end else begin
      valid_reg[0] <= accept;
      rd_reg[0]    <= accept & ~i_wb_we;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        rd_reg[i]    <= rd_reg[i-1];
      end
    end
  end

  assign o_wb_ack  = valid_reg[LATENCY-1] & i_wb_cyc;
  assign o_wb_data = (o_wb_ack && rd_reg[LATENCY-1]) ? data_pipe_reg[LATENCY-1] : '0;

  if (STALL_PERIOD >= 2) begin : g_stall
    logic [CW-1:0] stall_cnt_reg;

    // Free-running; bus activity does not influence the stall pattern.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        stall_cnt_reg <= '0;
      end else if (stall_cnt_reg == CW'(STALL_PERIOD - 1)) begin
        stall_cnt_reg <= '0;
      end else begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end

    assign stall_tick = (stall_cnt_reg == CW'(STALL_PERIOD - 1));
  end else begin : g_no_stall
    assign stall_tick = 1'b0;
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: three instances (LATENCY 1, LATENCY 3,
// LATENCY 2 with stall period 4) share clock and reset.
module tb_wb_ram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic [3:0]  sel   [3];
  logic        stall [3];
  logic        ack   [3];
  logic [31:0] rdat  [3];

  int ec = 0;
  int scnt = 0;
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    int          n;
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  wb_ram_slave #(.BYTES(32), .DEPTH(1024), .LATENCY(1), .STALL_PERIOD(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_addr(addr[0]), .i_wb_data(wdat[0]), .i_wb_sel(sel[0]),
    .o_wb_stall(stall[0]), .o_wb_ack(ack[0]), .o_wb_data(rdat[0]));

  wb_ram_slave #(.BYTES(32), .DEPTH(1024), .LATENCY(3), .STALL_PERIOD(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_addr(addr[1]), .i_wb_data(wdat[1]), .i_wb_sel(sel[1]),
    .o_wb_stall(stall[1]), .o_wb_ack(ack[1]), .o_wb_data(rdat[1]));

  wb_ram_slave #(.BYTES(32), .DEPTH(1024), .LATENCY(2), .STALL_PERIOD(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
    .i_wb_addr(addr[2]), .i_wb_data(wdat[2]), .i_wb_sel(sel[2]),
    .o_wb_stall(stall[2]), .o_wb_ack(ack[2]), .o_wb_data(rdat[2]));

  function automatic int lat(input int n);
    case (n)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // Cycle index and the expected stall counter of instance u2.
  always @(posedge clk) begin
    ec <= ec + 1;
    if (rst) scnt <= 0;
    else     scnt <= (scnt == 3) ? 0 : scnt + 1;
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req_v, ec);
    end
  endtask

  function automatic void flush(input int n);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].n == n) sb.delete(i);
    end
  endfunction

  // Monitor: compares every ack against the oldest expectation of its instance.
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      logic exp_stall;
      int   idx;
      exp_stall = rst || (n == 2 && scnt == 3);
      check(stall[n] === exp_stall, $sformatf("stall_u%0d", n), 32'(stall[n]), 32'(exp_stall));
      if (!cyc[n]) begin
        check(ack[n] === 1'b0, $sformatf("ack_without_cyc_u%0d", n), 32'(ack[n]), 32'd0);
        flush(n);
      end else begin
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].n == n) idx = i;
        if (ack[n] === 1'b1) begin
          if (idx < 0) begin
            check(1'b0, $sformatf("unexpected_ack_u%0d", n), 32'(ack[n]), 32'd0);
          end else begin
            check(rdat[n] === sb[idx].data, $sformatf("ack_data_u%0d", n), rdat[n], sb[idx].data);
            check(ec == sb[idx].due, $sformatf("ack_cycle_u%0d", n), 32'(ec), 32'(sb[idx].due));
            sb.delete(idx);
          end
        end else begin
          check(rdat[n] === 32'h0, $sformatf("idle_data_u%0d", n), rdat[n], 32'h0);
          if (idx >= 0 && sb[idx].due <= ec) begin
            check(1'b0, $sformatf("missing_ack_u%0d", n), 32'(ec), 32'(sb[idx].due));
            sb.delete(idx);
          end
        end
        if (rst) flush(n);
      end
    end
  end

  // Presents one request, holding it through stalls; returns just after the
  // accept edge with stb still asserted so requests can run back to back.
  task automatic req(input int n, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp_rd);
    bit done;
    exp_t e;
    done = 1'b0;
    cyc[n] = 1'b1; stb[n] = 1'b1; we[n] = w; addr[n] = a; wdat[n] = d; sel[n] = s;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (stall[n] === 1'b0) begin
        e.n    = n;
        e.due  = ec + lat(n);
        e.data = w ? 32'h0 : exp_rd;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check(1'b0, $sformatf("accept_timeout_u%0d", n), a, 32'h0);
  endtask

  task automatic idle(input int n, input int c);
    stb[n] = 1'b0;
    we[n]  = 1'b0;
    repeat (c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc[n] = 1'b0; stb[n] = 1'b0; we[n] = 1'b0;
      addr[n] = '0; wdat[n] = '0; sel[n] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(ack[0] === 1'b0, "reset_ack", 32'(ack[0]), 32'd0);
    check(rdat[0] === 32'h0, "reset_data", rdat[0], 32'h0);
    @(posedge clk); #1;

    // LATENCY=1: write/read-back, byte lanes, sel=0 write, sel ignored on read
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    req(0, 1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF);
    req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0);
    req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0);
    req(0, 1'b0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD);
    req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0);
    req(0, 1'b0, 32'h23, 32'h0,        4'h0, 32'h11BB33DD);
    req(0, 1'b0, 32'h10, 32'h0,        4'h2, 32'hDEADBEEF);
    idle(0, 3);
    cyc[0] = 1'b0;

    // LATENCY=3: preload then back-to-back reads
    req(1, 1'b1, 32'h0, 32'd1, 4'hF, 32'h0);
    req(1, 1'b1, 32'h4, 32'd2, 4'hF, 32'h0);
    req(1, 1'b1, 32'h8, 32'd3, 4'hF, 32'h0);
    req(1, 1'b0, 32'h0, 32'h0, 4'hF, 32'd1);
    req(1, 1'b0, 32'h4, 32'h0, 4'hF, 32'd2);
    req(1, 1'b0, 32'h8, 32'h0, 4'hF, 32'd3);
    idle(1, 5);

    // Abort: drop cyc the cycle after the write is accepted
    req(1, 1'b1, 32'h40, 32'h55, 4'hF, 32'h0);
    cyc[1] = 1'b0;
    idle(1, 4);
    cyc[1] = 1'b1;
    idle(1, 1);
    req(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h55);
    idle(1, 5);

    // Address wrap: 0x1000 aliases word 0
    req(1, 1'b1, 32'h1000, 32'h77, 4'hF, 32'h0);
    req(1, 1'b0, 32'h0,    32'h0,  4'hF, 32'h77);
    idle(1, 5);

    // Reset with two reads outstanding and a request presented during reset
    req(1, 1'b0, 32'h0, 32'h0, 4'hF, 32'h77);
    req(1, 1'b0, 32'h4, 32'h0, 4'hF, 32'd2);
    rst = 1'b1;
    addr[1] = 32'h8;
    @(posedge clk); #1;
    rst = 1'b0;
    stb[1] = 1'b0;
    @(negedge clk);
    check(ack[1] === 1'b0, "post_reset_ack", 32'(ack[1]), 32'd0);
    check(rdat[1] === 32'h0, "post_reset_data", rdat[1], 32'h0);
    @(posedge clk); #1;
    idle(1, 6);
    cyc[1] = 1'b0;

    // Stall period 4: preload, then eight reads with stb held throughout
    for (int i = 0; i < 8; i++) req(2, 1'b1, 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) req(2, 1'b0, 32'(4 * i), 32'h0, 4'hF, 32'hA0 + 32'(i));
    idle(2, 6);
    cyc[2] = 1'b0;
    idle(2, 2);

    check(sb.size() == 0, "pending_expectations", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
